// File: rtl/eth_pkg.sv
// eth_pkg: shared Ethernet/ARP constants, frame byte offsets, CRC constants
// and the receive-parser state enumeration.
package eth_pkg;

  localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
  localparam logic [15:0] ETH_TYPE_IP   = 16'h0800;
  localparam logic [15:0] ARP_OP_REQ    = 16'h0001;
  localparam logic [15:0] ARP_OP_RESP   = 16'h0002;
  localparam logic [15:0] ARP_HTYPE_ETH = 16'h0001;
  localparam logic [7:0]  ARP_HLEN_ETH  = 8'd6;
  localparam logic [7:0]  ARP_PLEN_IP   = 8'd4;

  localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE      = 8'hD5;

  // Byte offsets counted from the first byte after the SFD
  localparam int OFS_DST_MAC  = 0;
  localparam int OFS_ETH_TYPE = 12;
  localparam int OFS_HTYPE    = 14;
  localparam int OFS_PTYPE    = 16;
  localparam int OFS_HLEN     = 18;
  localparam int OFS_PLEN     = 19;
  localparam int OFS_OPCODE   = 20;
  localparam int OFS_SHA      = 22;
  localparam int OFS_SPA      = 28;
  localparam int OFS_TPA      = 38;

  // Shortest frame that still carries the whole ARP body (plus FCS when checked)
  localparam int MIN_LEN_NOFCS = 42;
  localparam int MIN_LEN_FCS   = 46;

  // CRC residue in MSB-first notation; the reflected poly drives the shift-right engine
  localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;
  localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_BODY,
    ST_CHECK,
    ST_DROP
  } arp_rx_state_t;

  // True when byte index idx lies inside the field [ofs, ofs+len)
  function automatic logic in_field(input logic [5:0] idx, input int ofs, input int len);
    return (int'(idx) >= ofs) && (int'(idx) < ofs + len);
  endfunction

  // Bit reversal, used to express the residue in the shift-right register's bit order
  function automatic logic [31:0] bitrev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = v[31-i];
    return r;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// crc32_d8: one byte of reflected CRC-32 (LSB-first), purely combinational.
module crc32_d8
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  data,
  output logic [31:0] crc_out
);

  // Fold the byte in, then step the shift-right LFSR eight times
  always_comb begin
    logic [31:0] c;
    c = crc_in ^ {24'd0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY_REFL) : (c >> 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/arp_req_rx.sv
// arp_req_rx: MII/GMII receive-side ARP request parser.
// Strips preamble/SFD, captures header and ARP fields by byte index, and in a
// one-cycle CHECK state emits frame_end/eth_type and, for accepted requests,
// req_valid with the requester's MAC/IP.
// Optional build macro ARP_RX_FCS_CHECK_EN: adds a CRC-32 FCS check and raises
// the minimum frame length to 46 bytes.
module arp_req_rx
  import eth_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC = 48'h000a35028846,
  parameter logic [31:0] LOCAL_IP  = 32'hc0a800ae
) (
  input  logic        rx_clk,
  input  logic        rst_n,
  input  logic        rx_dv,
  input  logic        rx_er,
  input  logic [7:0]  rxd,
  output logic        frame_end,
  output logic [15:0] eth_type,
  output logic        req_valid,
  output logic [47:0] req_mac,
  output logic [31:0] req_ip,
  output logic [15:0] drop_cnt
);

`ifdef ARP_RX_FCS_CHECK_EN
  localparam int MIN_LEN = MIN_LEN_FCS;
`else
  localparam int MIN_LEN = MIN_LEN_NOFCS;
`endif

  arp_rx_state_t state_reg, state_next;

  logic [5:0]  idx_reg;
  logic        body_seen_reg;
  logic        err_reg;
  logic [47:0] dst_mac_reg;
  logic [15:0] type_reg;
  logic [15:0] htype_reg;
  logic [15:0] ptype_reg;
  logic [7:0]  hlen_reg;
  logic [7:0]  plen_reg;
  logic [15:0] oper_reg;
  logic [47:0] sha_reg;
  logic [31:0] spa_reg;
  logic [31:0] tpa_reg;

  logic sfd_hit;
  logic body_byte;
  logic body_err;
  logic fcs_ok;
  logic accept;

  assign sfd_hit   = (state_reg == ST_PRE) && rx_dv && (rxd == SFD_BYTE);
  assign body_byte = (state_reg == ST_BODY) && rx_dv && !rx_er;
  assign body_err  = (state_reg == ST_BODY) && rx_dv && rx_er;

  // State register
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) state_reg <= ST_IDLE;
    else        state_reg <= state_next;
  end

  // Next-state decode; CHECK always lasts exactly one cycle and ignores rx_dv
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (rx_dv) state_next = (rxd == PREAMBLE_BYTE) ? ST_PRE : ST_DROP;
      end
      ST_PRE: begin
        if (!rx_dv)                     state_next = ST_IDLE;
        else if (rxd == SFD_BYTE)       state_next = ST_BODY;
        else if (rxd != PREAMBLE_BYTE)  state_next = ST_DROP;
      end
      ST_BODY: begin
        if (!rx_dv)     state_next = ST_CHECK;
        else if (rx_er) state_next = ST_DROP;
      end
      ST_CHECK: state_next = ST_IDLE;
      ST_DROP: begin
        if (!rx_dv) state_next = body_seen_reg ? ST_CHECK : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Byte index and shadow field capture; shadows clear at SFD so short frames read as zero
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg       <= '0;
      body_seen_reg <= 1'b0;
      err_reg       <= 1'b0;
      dst_mac_reg   <= '0;
      type_reg      <= '0;
      htype_reg     <= '0;
      ptype_reg     <= '0;
      hlen_reg      <= '0;
      plen_reg      <= '0;
      oper_reg      <= '0;
      sha_reg       <= '0;
      spa_reg       <= '0;
      tpa_reg       <= '0;
    end else if (sfd_hit) begin
      idx_reg       <= '0;
      body_seen_reg <= 1'b1;
      err_reg       <= 1'b0;
      dst_mac_reg   <= '0;
      type_reg      <= '0;
      htype_reg     <= '0;
      ptype_reg     <= '0;
      hlen_reg      <= '0;
      plen_reg      <= '0;
      oper_reg      <= '0;
      sha_reg       <= '0;
      spa_reg       <= '0;
      tpa_reg       <= '0;
    end else if (body_byte) begin
      // Saturation at 63 keeps trailing bytes of long frames out of every field
      if (idx_reg != 6'd63) idx_reg <= idx_reg + 6'd1;
      if (in_field(idx_reg, OFS_DST_MAC, 6))  dst_mac_reg <= {dst_mac_reg[39:0], rxd};
      if (in_field(idx_reg, OFS_ETH_TYPE, 2)) type_reg    <= {type_reg[7:0], rxd};
      if (in_field(idx_reg, OFS_HTYPE, 2))    htype_reg   <= {htype_reg[7:0], rxd};
      if (in_field(idx_reg, OFS_PTYPE, 2))    ptype_reg   <= {ptype_reg[7:0], rxd};
      if (in_field(idx_reg, OFS_HLEN, 1))     hlen_reg    <= rxd;
      if (in_field(idx_reg, OFS_PLEN, 1))     plen_reg    <= rxd;
      if (in_field(idx_reg, OFS_OPCODE, 2))   oper_reg    <= {oper_reg[7:0], rxd};
      if (in_field(idx_reg, OFS_SHA, 6))      sha_reg     <= {sha_reg[39:0], rxd};
      if (in_field(idx_reg, OFS_SPA, 4))      spa_reg     <= {spa_reg[23:0], rxd};
      if (in_field(idx_reg, OFS_TPA, 4))      tpa_reg     <= {tpa_reg[23:0], rxd};
    end else if (body_err) begin
      err_reg <= 1'b1;
    end else if (state_reg == ST_IDLE) begin
      body_seen_reg <= 1'b0;
      err_reg       <= 1'b0;
    end
  end

`ifdef ARP_RX_FCS_CHECK_EN
  logic [31:0] crc_reg;
  logic [31:0] crc_next;

  crc32_d8 u_crc32_d8 (
    .crc_in  (crc_reg),
    .data    (rxd),
    .crc_out (crc_next)
  );

  // Running CRC over every body byte, FCS included
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n)         crc_reg <= '1;
    else if (sfd_hit)   crc_reg <= '1;
    else if (body_byte) crc_reg <= crc_next;
  end

  assign fcs_ok = (crc_reg == bitrev32(CRC_RESIDUE));
`else
  assign fcs_ok = 1'b1;
`endif

  assign accept = !err_reg
               && (int'(idx_reg) >= MIN_LEN)
               && ((dst_mac_reg == 48'hffff_ffff_ffff) || (dst_mac_reg == LOCAL_MAC))
               && (htype_reg == ARP_HTYPE_ETH)
               && (ptype_reg == ETH_TYPE_IP)
               && (hlen_reg == ARP_HLEN_ETH)
               && (plen_reg == ARP_PLEN_IP)
               && (oper_reg == ARP_OP_REQ)
               && (tpa_reg == LOCAL_IP)
               && fcs_ok;

  // Registered outputs: pulses and held values all update on the edge leaving CHECK
  always_ff @(posedge rx_clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_end <= 1'b0;
      req_valid <= 1'b0;
      eth_type  <= '0;
      req_mac   <= '0;
      req_ip    <= '0;
      drop_cnt  <= '0;
    end else begin
      frame_end <= (state_reg == ST_CHECK);
      req_valid <= (state_reg == ST_CHECK) && accept;
      if (state_reg == ST_CHECK) begin
        eth_type <= type_reg;
        if (accept) begin
          req_mac <= sha_reg;
          req_ip  <= spa_reg;
        end else if ((type_reg == ETH_TYPE_ARP) && (drop_cnt != 16'hffff)) begin
          drop_cnt <= drop_cnt + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_arp_req_rx.sv
// tb_arp_req_rx: directed plus randomized frames against a byte-array reference
// model of the ARP request acceptance rules.
module tb_arp_req_rx;

  localparam logic [47:0] LOCAL_MAC = 48'h000a35028846;
  localparam logic [31:0] LOCAL_IP  = 32'hc0a800ae;
  localparam logic [47:0] BCAST     = 48'hffff_ffff_ffff;
`ifdef ARP_RX_FCS_CHECK_EN
  localparam int MIN_LEN = 46;
`else
  localparam int MIN_LEN = 42;
`endif

  logic        rx_clk = 1'b0;
  logic        rst_n  = 1'b0;
  logic        rx_dv  = 1'b0;
  logic        rx_er  = 1'b0;
  logic [7:0]  rxd    = 8'h00;
  logic        frame_end;
  logic [15:0] eth_type;
  logic        req_valid;
  logic [47:0] req_mac;
  logic [31:0] req_ip;
  logic [15:0] drop_cnt;

  arp_req_rx #(.LOCAL_MAC(LOCAL_MAC), .LOCAL_IP(LOCAL_IP)) dut (
    .rx_clk    (rx_clk),
    .rst_n     (rst_n),
    .rx_dv     (rx_dv),
    .rx_er     (rx_er),
    .rxd       (rxd),
    .frame_end (frame_end),
    .eth_type  (eth_type),
    .req_valid (req_valid),
    .req_mac   (req_mac),
    .req_ip    (req_ip),
    .drop_cnt  (drop_cnt)
  );

  always #5 rx_clk = ~rx_clk;

  int errors = 0;
  int checks = 0;

  // Edge counter and pulse monitor (samples on the falling edge)
  int edge_no = 0;
  always @(posedge rx_clk) edge_no <= edge_no + 1;

  int          fe_cnt = 0, rv_cnt = 0, fe_edge = -1, rv_edge = -1;
  logic [15:0] fe_type = '0;
  logic [47:0] rv_mac = '0;
  logic [31:0] rv_ip = '0;
  always @(negedge rx_clk) begin
    if (frame_end === 1'b1) begin
      fe_cnt++; fe_edge = edge_no; fe_type = eth_type;
    end
    if (req_valid === 1'b1) begin
      rv_cnt++; rv_edge = edge_no; rv_mac = req_mac; rv_ip = req_ip;
    end
  end

  // Reference state
  logic [7:0]  frm[$];
  int          exp_fe = 0, exp_rv = 0;
  logic [15:0] exp_type = '0, exp_drop = '0;
  logic [47:0] exp_mac = '0;
  logic [31:0] exp_ip = '0;
  int          dv0_edge = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] fcs_of(input int n);
    logic [31:0] c;
    c = 32'hffffffff;
    for (int i = 0; i < n; i++) begin
      c = c ^ {24'd0, frm[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  function automatic logic [47:0] fld(input int ofs, input int len, input int ncap);
    logic [47:0] v;
    v = '0;
    for (int i = 0; i < len; i++) v = {v[39:0], (ofs + i < ncap) ? frm[ofs+i] : 8'h00};
    return v;
  endfunction

  task automatic push_be(input logic [47:0] v, input int nb);
    for (int i = nb - 1; i >= 0; i--) frm.push_back(v[i*8 +: 8]);
  endtask

  task automatic append_fcs();
    logic [31:0] f;
    f = fcs_of(frm.size());
    for (int i = 0; i < 4; i++) frm.push_back(f[i*8 +: 8]);
  endtask

  task automatic build_arp(input logic [47:0] dst, input logic [15:0] et, input logic [15:0] ht,
                           input logic [15:0] pt, input logic [7:0] hl, input logic [7:0] pl,
                           input logic [15:0] op, input logic [47:0] sha, input logic [31:0] spa,
                           input logic [31:0] tpa, input int dlen);
    frm.delete();
    push_be(dst, 6); push_be(48'h021122334401, 6); push_be(et, 2);
    push_be(ht, 2); push_be(pt, 2); push_be(hl, 1); push_be(pl, 1); push_be(op, 2);
    push_be(sha, 6); push_be(spa, 4); push_be(48'h0, 6); push_be(tpa, 4);
    while (frm.size() < 60) frm.push_back(8'h00);
    while (frm.size() > dlen) void'(frm.pop_back());
    append_fcs();
  endtask

  task automatic drive(input logic dv, input logic er, input logic [7:0] d);
    @(negedge rx_clk);
    rx_dv = dv; rx_er = er; rxd = d;
  endtask

  task automatic send_raw(input int pre_len, input int err_at);
    for (int i = 0; i < pre_len; i++) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hd5);
    for (int i = 0; i < frm.size(); i++) drive(1'b1, (i == err_at), frm[i]);
    drive(1'b0, 1'b0, 8'h00);
    dv0_edge = edge_no;
  endtask

  // Acceptance rules applied to the byte array; fields not received read as zero
  task automatic model_frame(input int err_at, output bit acc, output logic [15:0] t);
    int n, ncap;
    n = frm.size();
    ncap = (err_at >= 0) ? err_at : n;
    t = fld(12, 2, ncap);
    acc = (err_at < 0) && (ncap >= MIN_LEN)
       && ((fld(0, 6, ncap) == BCAST) || (fld(0, 6, ncap) == LOCAL_MAC))
       && (fld(14, 2, ncap) == 48'h0001) && (fld(16, 2, ncap) == 48'h0800)
       && (fld(18, 1, ncap) == 48'd6) && (fld(19, 1, ncap) == 48'd4)
       && (fld(20, 2, ncap) == 48'h0001) && (fld(38, 4, ncap) == {16'd0, LOCAL_IP});
`ifdef ARP_RX_FCS_CHECK_EN
    acc = acc && ({frm[n-1], frm[n-2], frm[n-3], frm[n-4]} == fcs_of(n - 4));
`endif
    exp_fe++;
    exp_type = t;
    if (acc) begin
      exp_rv++;
      exp_mac = fld(22, 6, ncap);
      exp_ip  = fld(28, 4, ncap);
    end else if (t == 16'h0806 && exp_drop != 16'hffff) begin
      exp_drop++;
    end
  endtask

  task automatic verify(input string tag, input bit reached, input bit acc,
                        input logic [15:0] t, input int e0);
    repeat (4) drive(1'b0, 1'b0, 8'h00);
    #2;
    chk({tag, " frame_end count"}, fe_cnt, exp_fe);
    chk({tag, " req_valid count"}, rv_cnt, exp_rv);
    if (reached) begin
      chk({tag, " frame_end edge"}, fe_edge, e0 + 2);
      chk({tag, " eth_type at frame_end"}, fe_type, t);
    end
    if (acc) begin
      chk({tag, " req_valid edge"}, rv_edge, e0 + 2);
      chk({tag, " req_mac at pulse"}, rv_mac, exp_mac);
      chk({tag, " req_ip at pulse"}, rv_ip, exp_ip);
    end
    chk({tag, " eth_type held"}, eth_type, exp_type);
    chk({tag, " req_mac held"}, req_mac, exp_mac);
    chk({tag, " req_ip held"}, req_ip, exp_ip);
    chk({tag, " drop_cnt"}, drop_cnt, exp_drop);
  endtask

  task automatic run_frame(input string tag, input int pre_len, input int err_at);
    bit acc;
    logic [15:0] t;
    model_frame(err_at, acc, t);
    send_raw(pre_len, err_at);
    verify(tag, 1'b1, acc, t, dv0_edge);
  endtask

  initial begin
    bit acc;
    logic [15:0] t;
    int e0, dlen, err_at, sel;
    logic [63:0] r64;
    logic [47:0] dst, sha;
    logic [15:0] et, ht, pt, op;
    logic [7:0] hl, pl;
    logic [31:0] spa, tpa;

    // Reset state
    repeat (3) @(negedge rx_clk);
    chk("reset frame_end", frame_end, 0);
    chk("reset req_valid", req_valid, 0);
    chk("reset eth_type", eth_type, 0);
    chk("reset req_mac", req_mac, 0);
    chk("reset req_ip", req_ip, 0);
    chk("reset drop_cnt", drop_cnt, 0);
    rst_n = 1'b1;
    repeat (2) drive(1'b0, 1'b0, 8'h00);

    // Directed: valid broadcast request
    build_arp(BCAST, 16'h0806, 16'h0001, 16'h0800, 8'd6, 8'd4, 16'h0001,
              48'h6c626d802701, 32'hc0a800af, 32'hc0a800ae, 60);
    run_frame("bcast_req", 7, -1);
    // Same request, wrong target IP
    build_arp(BCAST, 16'h0806, 16'h0001, 16'h0800, 8'd6, 8'd4, 16'h0001,
              48'h6c626d802701, 32'hc0a800af, 32'hc0a800b0, 60);
    run_frame("wrong_tpa", 7, -1);
    // IPv4 frame, 60 bytes + FCS
    frm.delete();
    push_be(BCAST, 6); push_be(48'h021122334401, 6); push_be(16'h0800, 2);
    while (frm.size() < 60) frm.push_back(8'($urandom_range(0, 255)));
    append_fcs();
    run_frame("ipv4", 7, -1);
    // rx_er at byte 25 of a valid request
    build_arp(LOCAL_MAC, 16'h0806, 16'h0001, 16'h0800, 8'd6, 8'd4, 16'h0001,
              48'h6c626d8027aa, 32'hc0a800b1, 32'hc0a800ae, 60);
    run_frame("rx_er_25", 7, 25);
    // One FCS bit flipped
    build_arp(BCAST, 16'h0806, 16'h0001, 16'h0800, 8'd6, 8'd4, 16'h0001,
              48'h6c626d802702, 32'hc0a800b2, 32'hc0a800ae, 60);
    frm[frm.size()-1] = frm[frm.size()-1] ^ 8'h10;
    run_frame("fcs_flip", 7, -1);

    // Randomized frames
    for (int f = 0; f < 40; f++) begin
      sel = $urandom_range(0, 2);
      r64 = {$urandom, $urandom};
      dst = (sel == 0) ? BCAST : (sel == 1) ? LOCAL_MAC : r64[47:0];
      r64 = {$urandom, $urandom};
      sha = r64[47:0];
      spa = $urandom;
      et  = ($urandom_range(0, 4) == 0) ? 16'h0800 : 16'h0806;
      ht = 16'h0001; pt = 16'h0800; hl = 8'd6; pl = 8'd4;
      case ($urandom_range(0, 7))
        0: ht = 16'h0002;
        1: pt = 16'h86dd;
        2: hl = 8'd8;
        3: pl = 8'd16;
        default: ;
      endcase
      op  = ($urandom_range(0, 3) == 0) ? 16'h0002 : 16'h0001;
      tpa = ($urandom_range(0, 2) == 0) ? (LOCAL_IP ^ 32'h1) : LOCAL_IP;
      dlen = ($urandom_range(0, 3) == 0) ? $urandom_range(30, 59) : 60;
      build_arp(dst, et, ht, pt, hl, pl, op, sha, spa, tpa, dlen);
      err_at = ($urandom_range(0, 5) == 0) ? $urandom_range(0, frm.size() - 1) : -1;
      run_frame($sformatf("rand%0d", f), $urandom_range(1, 7), err_at);
    end

    // Reset asserted at byte 10 of a valid request; the remainder must be silent
    build_arp(BCAST, 16'h0806, 16'h0001, 16'h0800, 8'd6, 8'd4, 16'h0001,
              48'h6c626d802703, 32'hc0a800b3, 32'hc0a800ae, 60);
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hd5);
    for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, frm[i]);
    @(negedge rx_clk);
    rst_n = 1'b0; rxd = frm[10];
    #1;
    chk("midreset frame_end", frame_end, 0);
    chk("midreset req_valid", req_valid, 0);
    chk("midreset eth_type", eth_type, 0);
    chk("midreset req_mac", req_mac, 0);
    chk("midreset req_ip", req_ip, 0);
    chk("midreset drop_cnt", drop_cnt, 0);
    exp_type = '0; exp_mac = '0; exp_ip = '0; exp_drop = '0;
    @(negedge rx_clk);
    rst_n = 1'b1; rxd = frm[11];
    for (int i = 12; i < frm.size(); i++) drive(1'b1, 1'b0, frm[i]);
    drive(1'b0, 1'b0, 8'h00);
    verify("partial", 1'b0, 1'b0, 16'h0, 0);

    // Valid request, then a 1-cycle gap before the next one (its preamble lands in CHECK)
    build_arp(LOCAL_MAC, 16'h0806, 16'h0001, 16'h0800, 8'd6, 8'd4, 16'h0001,
              48'h6c626d802704, 32'hc0a800b4, 32'hc0a800ae, 60);
    model_frame(-1, acc, t);
    send_raw(7, -1);
    e0 = dv0_edge;
    build_arp(BCAST, 16'h0806, 16'h0001, 16'h0800, 8'd6, 8'd4, 16'h0001,
              48'h6c626d802705, 32'hc0a800b5, 32'hc0a800ae, 60);
    send_raw(1, -1);
    verify("gap", 1'b1, acc, t, e0);
    chk("gap accepted first", acc, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
